// File: rtl/sensor_scan_scheduler_pkg.sv
// Shared types and constants for the three-sensor scan scheduler.
package sensor_scan_pkg;

   localparam int N_SENSORS = 3;
   localparam int IDX_W     = 2;
   localparam int SAT_MAX   = 999;

   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SENSORS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRIG = 2'd1,
      ST_WAIT = 2'd2,
      ST_GAP  = 2'd3
   } scan_state_e;

   function automatic logic [N_SENSORS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      idx_onehot = {{(N_SENSORS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/sensor_scan_scheduler_timer.sv
// Clearable up-counter shared by the response-timeout and settle-gap phases;
// sel_gap picks which terminal count applies.
module scan_timer #(
   parameter int GAP_CYCLES     = 3000000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int CNT_W          = 22
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic sel_gap,
   output logic terminal
);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] limit_s;

   // Terminal value for the phase that currently owns the counter
   always_comb begin
      if (sel_gap) begin
         limit_s = CNT_W'(GAP_CYCLES - 1);
      end else begin
         limit_s = CNT_W'(TIMEOUT_CYCLES - 1);
      end
   end

   assign terminal = (count_r == limit_s);

   // Counter; the owner clears it on terminal so it never wraps
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Round-robin trigger/collect scheduler for three sensors with settle gap and timeout.
// Define SENSOR_SAT_EN to clamp latched values to 999 for the 3-digit display.
module sensor_scan_scheduler
   import sensor_scan_pkg::*;
#(
   parameter int GAP_CYCLES     = 3000000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int DATA_W         = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic [N_SENSORS-1:0] start,
   input  logic [N_SENSORS-1:0] done,
   input  logic [DATA_W-1:0]    result1,
   input  logic [DATA_W-1:0]    result2,
   input  logic [DATA_W-1:0]    result3,
   output logic [DATA_W-1:0]    val1,
   output logic [DATA_W-1:0]    val2,
   output logic [DATA_W-1:0]    val3,
   output logic [N_SENSORS-1:0] err,
   output logic [IDX_W-1:0]     active_idx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int LIM_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(LIM_MAX + 1);

   scan_state_e            state_r;
   logic [IDX_W-1:0]       idx_r;
   logic [N_SENSORS-1:0]   start_r;
   logic [N_SENSORS-1:0]   err_r;
   logic [DATA_W-1:0]      val_r [N_SENSORS];
   logic                   busy_r;
   logic                   frame_done_r;
   logic [DATA_W-1:0]      result_s [N_SENSORS];
   logic                   hit_s;
   logic                   clear_s;
   logic                   sel_gap_s;
   logic                   tc_s;

   function automatic logic [DATA_W-1:0] latch_value(input logic [DATA_W-1:0] raw);
`ifdef SENSOR_SAT_EN
      latch_value = (raw > DATA_W'(SAT_MAX)) ? DATA_W'(SAT_MAX) : raw;
`else
      latch_value = raw;
`endif
   endfunction

   assign result_s[0] = result1;
   assign result_s[1] = result2;
   assign result_s[2] = result3;

   scan_timer #(
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_s),
      .sel_gap  (sel_gap_s),
      .terminal (tc_s)
   );

   // Timer ownership: only WAIT and GAP count, and each leaves with a cleared timer
   always_comb begin
      sel_gap_s = (state_r == ST_GAP);
      hit_s     = 1'b0;
      clear_s   = 1'b1;
      case (state_r)
         ST_WAIT: begin
            hit_s   = done[idx_r];
            clear_s = done[idx_r] | tc_s;
         end
         ST_GAP: begin
            clear_s = tc_s;
         end
         default: begin
            clear_s = 1'b1;
         end
      endcase
   end

   // Scan FSM with registered trigger, result, flag and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         idx_r        <= IDX_ZERO;
         start_r      <= {N_SENSORS{1'b0}};
         err_r        <= {N_SENSORS{1'b0}};
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         for (int i = 0; i < N_SENSORS; i++) begin
            val_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         start_r      <= {N_SENSORS{1'b0}};
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               idx_r <= IDX_ZERO;
               if (enable) begin
                  state_r <= ST_TRIG;
                  busy_r  <= 1'b1;
                  start_r <= idx_onehot(IDX_ZERO);
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_TRIG: begin
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving on the timeout cycle still counts as success
               if (hit_s) begin
                  val_r[idx_r] <= latch_value(result_s[idx_r]);
                  err_r[idx_r] <= 1'b0;
                  state_r      <= ST_GAP;
               end else if (tc_s) begin
                  err_r[idx_r] <= 1'b1;
                  state_r      <= ST_GAP;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_GAP: begin
               if (!tc_s) begin
                  state_r <= ST_GAP;
               end else if (idx_r != IDX_LAST) begin
                  idx_r   <= idx_r + IDX_ONE;
                  state_r <= ST_TRIG;
                  start_r <= idx_onehot(idx_r + IDX_ONE);
               end else begin
                  // enable is only honoured here, so a frame is never cut short
                  frame_done_r <= 1'b1;
                  idx_r        <= IDX_ZERO;
                  if (enable) begin
                     state_r <= ST_TRIG;
                     start_r <= idx_onehot(IDX_ZERO);
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= IDX_ZERO;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign start      = start_r;
   assign err        = err_r;
   assign val1       = val_r[0];
   assign val2       = val_r[1];
   assign val3       = val_r[2];
   assign active_idx = idx_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;

endmodule
